// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit
// Description : Fetches one instruction word per PC value. It reads pc_atual,
//               issues a req/ack read to instruction memory, and hands the word
//               to the decoder over a valid/ready handshake. It then computes
//               the next PC (sequential or branch) and pulses the PC register
//               write-enable for one cycle.
//
// Ports       : clock       - system clock, rising edge
//               reset       - asynchronous active-low reset
//               enable      - fetch permitted (sampled only when idle)
//               pc_atual    - current PC from the PC register
//               entrada_pc  - next PC to the PC register
//               esc_pc      - PC register write-enable (one-cycle pulse)
//               mem_req     - instruction-memory read request
//               mem_addr    - instruction-memory address
//               mem_ack     - memory read data valid
//               mem_rdata   - memory read data
//               instr       - fetched instruction
//               instr_valid - instr holds an unconsumed instruction
//               instr_ready - decoder accepts instr
//               desvio      - take branch to alvo instead of incrementing
//               alvo        - branch target
//               erro        - sticky fetch-timeout flag
//
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 16,
    parameter int PC_INC   = 1,
    parameter int MAX_WAIT = 15
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic [ADDR_W-1:0] pc_atual,
    output logic [ADDR_W-1:0] entrada_pc,
    output logic              esc_pc,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              desvio,
    input  logic [ADDR_W-1:0] alvo,
    output logic              erro
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    localparam logic [1:0] c_ST_OCIOSO   = 2'd0;
    localparam logic [1:0] c_ST_PEDE     = 2'd1;
    localparam logic [1:0] c_ST_ENTREGA  = 2'd2;
    localparam logic [1:0] c_ST_ATUALIZA = 2'd3;

    // The counter starts at 0 on entry to PEDE and advances once per edge
    // without ack, so the request stays up for exactly MAX_WAIT cycles.
    localparam logic [CNT_W-1:0]  c_WAIT_LAST = CNT_W'(MAX_WAIT - 1);
    localparam logic [ADDR_W-1:0] c_PC_INC    = ADDR_W'(PC_INC);

    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_wait;
    logic [ADDR_W-1:0] r_entrada_pc;
    logic              r_esc_pc;
    logic              r_mem_req;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_instr;
    logic              r_instr_valid;
    logic              r_erro;

    // Next sequential PC; width truncation gives the modulo-2^ADDR_W wrap.
    logic [ADDR_W-1:0] w_pc_seq;
    assign w_pc_seq = pc_atual + c_PC_INC;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state       <= c_ST_OCIOSO;
            r_wait        <= '0;
            r_entrada_pc  <= '0;
            r_esc_pc      <= 1'b0;
            r_mem_req     <= 1'b0;
            r_mem_addr    <= '0;
            r_instr       <= '0;
            r_instr_valid <= 1'b0;
            r_erro        <= 1'b0;
        end else begin
            case (r_state)
                c_ST_OCIOSO: begin
                    r_esc_pc  <= 1'b0;
                    r_mem_req <= 1'b0;
                    if (enable) begin
                        r_mem_addr <= pc_atual;
                        r_mem_req  <= 1'b1;
                        r_wait     <= '0;
                        r_state    <= c_ST_PEDE;
                    end
                end
                c_ST_PEDE: begin
                    // Ack is tested first so that an ack arriving on the
                    // timeout edge completes the fetch instead of erroring.
                    if (mem_ack) begin
                        r_instr       <= mem_rdata;
                        r_instr_valid <= 1'b1;
                        r_mem_req     <= 1'b0;
                        r_state       <= c_ST_ENTREGA;
                    end else if (r_wait == c_WAIT_LAST) begin
                        r_mem_req <= 1'b0;
                        r_erro    <= 1'b1;
                        r_state   <= c_ST_OCIOSO;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                c_ST_ENTREGA: begin
                    if (instr_ready) begin
                        r_instr_valid <= 1'b0;
                        r_entrada_pc  <= desvio ? alvo : w_pc_seq;
                        r_esc_pc      <= 1'b1;
                        r_state       <= c_ST_ATUALIZA;
                    end
                end
                c_ST_ATUALIZA: begin
                    r_esc_pc <= 1'b0;
                    r_state  <= c_ST_OCIOSO;
                end
                default: begin
                    r_esc_pc  <= 1'b0;
                    r_mem_req <= 1'b0;
                    r_state   <= c_ST_OCIOSO;
                end
            endcase
        end
    end

    assign entrada_pc  = r_entrada_pc;
    assign esc_pc      = r_esc_pc;
    assign mem_req     = r_mem_req;
    assign mem_addr    = r_mem_addr;
    assign instr       = r_instr;
    assign instr_valid = r_instr_valid;
    assign erro        = r_erro;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch_unit
// Description : Directed self-checking bench for instr_fetch_unit. Inputs are
//               driven 1 ns after each rising edge and outputs are checked at
//               the same point, i.e. the registered result of that edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

    logic        clock;
    logic        reset;
    logic        enable;
    logic [7:0]  pc_atual;
    logic [7:0]  entrada_pc;
    logic        esc_pc;
    logic        mem_req;
    logic [7:0]  mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        desvio;
    logic [7:0]  alvo;
    logic        erro;

    int n_checks = 0;
    int n_fails  = 0;

    instr_fetch_unit #(
        .ADDR_W  (8),
        .DATA_W  (16),
        .PC_INC  (1),
        .MAX_WAIT(15)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .pc_atual   (pc_atual),
        .entrada_pc (entrada_pc),
        .esc_pc     (esc_pc),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .instr      (instr),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .desvio     (desvio),
        .alvo       (alvo),
        .erro       (erro)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".entrada_pc"},  32'(entrada_pc),  32'h0);
        check({tag, ".esc_pc"},      32'(esc_pc),      32'h0);
        check({tag, ".mem_req"},     32'(mem_req),     32'h0);
        check({tag, ".mem_addr"},    32'(mem_addr),    32'h0);
        check({tag, ".instr"},       32'(instr),       32'h0);
        check({tag, ".instr_valid"}, 32'(instr_valid), 32'h0);
        check({tag, ".erro"},        32'(erro),        32'h0);
    endtask

    // Watchdog so the run always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset       = 1'b0;
        enable      = 1'b0;
        pc_atual    = 8'h00;
        mem_ack     = 1'b0;
        mem_rdata   = 16'h0000;
        instr_ready = 1'b0;
        desvio      = 1'b0;
        alvo        = 8'h00;

        // ---------------- reset then basic fetch ----------------
        repeat (3) step();
        check_all_zero("reset");
        reset       = 1'b1;
        pc_atual    = 8'h10;
        enable      = 1'b1;
        instr_ready = 1'b1;

        step(); // OCIOSO -> PEDE
        check("basic.mem_req",  32'(mem_req),  32'h1);
        check("basic.mem_addr", 32'(mem_addr), 32'h10);
        enable    = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 16'hA5C3;

        step(); // PEDE -> ENTREGA
        check("basic.instr",       32'(instr),       32'hA5C3);
        check("basic.instr_valid", 32'(instr_valid), 32'h1);
        check("basic.mem_req_off", 32'(mem_req),     32'h0);
        check("basic.esc_pc_pre",  32'(esc_pc),      32'h0);
        mem_ack = 1'b0;

        step(); // ENTREGA -> ATUALIZA
        check("basic.valid_off",  32'(instr_valid), 32'h0);
        check("basic.esc_pc",     32'(esc_pc),      32'h1);
        check("basic.entrada_pc", 32'(entrada_pc),  32'h11);
        pc_atual = 8'h11; // PC register loads at the end of ATUALIZA
        enable   = 1'b1;

        step(); // ATUALIZA -> OCIOSO
        check("basic.esc_pc_off", 32'(esc_pc),  32'h0);
        check("basic.req_idle",   32'(mem_req), 32'h0);

        step(); // OCIOSO -> PEDE: fourth edge after the previous request
        check("period.mem_req",  32'(mem_req),  32'h1);
        check("period.mem_addr", 32'(mem_addr), 32'h11);
        enable = 1'b0;

        // ---------------- memory wait states ----------------
        for (int i = 0; i < 5; i++) begin
            step();
            check("wait.mem_req",  32'(mem_req),  32'h1);
            check("wait.mem_addr", 32'(mem_addr), 32'h11);
            check("wait.erro",     32'(erro),     32'h0);
        end
        mem_ack   = 1'b1;
        mem_rdata = 16'h1234;
        step();
        check("wait.instr",   32'(instr),       32'h1234);
        check("wait.valid",   32'(instr_valid), 32'h1);
        check("wait.req_off", 32'(mem_req),     32'h0);
        check("wait.erro2",   32'(erro),        32'h0);
        mem_ack     = 1'b0;
        instr_ready = 1'b0;
        desvio      = 1'b1; // ignored while not accepting
        alvo        = 8'h77;

        // ---------------- back-pressure with branch ----------------
        for (int i = 0; i < 4; i++) begin
            step();
            check("bp.instr",  32'(instr),       32'h1234);
            check("bp.valid",  32'(instr_valid), 32'h1);
            check("bp.esc_pc", 32'(esc_pc),      32'h0);
        end
        instr_ready = 1'b1;
        desvio      = 1'b1;
        alvo        = 8'h3C;
        step();
        check("bp.esc_pc_on",  32'(esc_pc),      32'h1);
        check("bp.entrada_pc", 32'(entrada_pc),  32'h3C);
        check("bp.valid_off",  32'(instr_valid), 32'h0);
        desvio   = 1'b0;
        alvo     = 8'h99;
        pc_atual = 8'h3C;
        step();
        check("bp.esc_pc_off", 32'(esc_pc),     32'h0);
        check("bp.pc_hold",    32'(entrada_pc), 32'h3C);

        // ---------------- ack on the timeout edge ----------------
        enable = 1'b1;
        step();
        check("tob.mem_req",  32'(mem_req),  32'h1);
        check("tob.mem_addr", 32'(mem_addr), 32'h3C);
        enable = 1'b0;
        for (int i = 0; i < 14; i++) step();
        check("tob.req_still", 32'(mem_req), 32'h1);
        mem_ack   = 1'b1;
        mem_rdata = 16'hBEEF;
        step(); // 15th edge in PEDE: ack wins
        check("tob.instr", 32'(instr),       32'hBEEF);
        check("tob.valid", 32'(instr_valid), 32'h1);
        check("tob.erro",  32'(erro),        32'h0);
        mem_ack = 1'b0;
        step(); // accepted, sequential
        check("tob.entrada_pc", 32'(entrada_pc), 32'h3D);
        check("tob.esc_pc",     32'(esc_pc),     32'h1);
        pc_atual = 8'h3D;
        step();

        // ---------------- timeout ----------------
        enable = 1'b1;
        step();
        check("toa.mem_req", 32'(mem_req), 32'h1);
        enable = 1'b0;
        for (int i = 0; i < 14; i++) begin
            step();
            check("toa.req_held", 32'(mem_req), 32'h1);
            check("toa.esc_pc",   32'(esc_pc),  32'h0);
            check("toa.erro_lo",  32'(erro),    32'h0);
        end
        step(); // 15th edge without ack
        check("toa.req_drop", 32'(mem_req),     32'h0);
        check("toa.erro",     32'(erro),        32'h1);
        check("toa.valid",    32'(instr_valid), 32'h0);
        mem_ack     = 1'b1; // ignored outside PEDE
        instr_ready = 1'b1;
        step();
        check("toa.erro_sticky", 32'(erro),        32'h1);
        check("toa.idle_req",    32'(mem_req),     32'h0);
        check("toa.idle_esc",    32'(esc_pc),      32'h0);
        check("toa.ack_ignored", 32'(instr_valid), 32'h0);
        mem_ack = 1'b0;

        // ---------------- wrap-around ----------------
        pc_atual  = 8'hFF;
        enable    = 1'b1;
        step();
        check("wrap.mem_addr", 32'(mem_addr), 32'hFF);
        enable    = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 16'h0F0F;
        step();
        check("wrap.instr", 32'(instr), 32'h0F0F);
        mem_ack = 1'b0;
        step();
        check("wrap.entrada_pc", 32'(entrada_pc), 32'h00);
        check("wrap.esc_pc",     32'(esc_pc),     32'h1);
        check("wrap.erro",       32'(erro),       32'h1);
        pc_atual = 8'h00;
        step();

        // ---------------- mid-fetch reset ----------------
        pc_atual = 8'h20;
        enable   = 1'b1;
        step();
        check("mrst.mem_req", 32'(mem_req), 32'h1);
        enable = 1'b0;
        #3;
        reset = 1'b0; // between edges
        #1;
        check_all_zero("mrst");
        #2;
        reset = 1'b1;
        step();
        check("mrst.idle_req", 32'(mem_req), 32'h0);
        enable = 1'b1;
        step(); // from OCIOSO a single edge starts a fetch
        check("mrst.restart_req",  32'(mem_req),  32'h1);
        check("mrst.restart_addr", 32'(mem_addr), 32'h20);
        enable = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Reads the current program-counter value, fetches one instruction word from instruction memory over a req/ack handshake, and hands it to the decoder over a valid/ready handshake.
- Computes the next PC value and drives the PC register's write-enable for exactly one cycle.
- Sits between the PC register and the decode/control stage. It is the consumer of the PC output and the producer of the PC input and write-enable.

Parameters:
- ADDR_W, 8: PC and instruction-memory address width.
- DATA_W, 16: instruction word width.
- PC_INC, 1: increment added to the PC on sequential flow.
- MAX_WAIT, 15: maximum cycles mem_req may stay high without mem_ack before a fetch error is declared.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  fetch permitted; sampled only in OCIOSO.
- pc_atual  in  ADDR_W  current PC value, from the PC register output.
- entrada_pc  out  ADDR_W  next PC value, to the PC register input.
- esc_pc  out  1  PC write-enable, to the PC register.
- mem_req  out  1  instruction-memory read request.
- mem_addr  out  ADDR_W  instruction-memory address.
- mem_ack  in  1  memory data valid.
- mem_rdata  in  DATA_W  memory read data.
- instr  out  DATA_W  fetched instruction.
- instr_valid  out  1  instr holds an unconsumed instruction.
- instr_ready  in  1  decoder accepts instr.
- desvio  in  1  take branch instead of the sequential increment.
- alvo  in  ADDR_W  branch target.
- erro  out  1  sticky fetch-timeout flag.

Behaviour:
- Reset (reset=0, asynchronous, any state):
  - state=OCIOSO; wait counter=0.
  - All outputs 0: entrada_pc, esc_pc, mem_req, mem_addr, instr, instr_valid, erro.
  - mem_req drops immediately, without waiting for a clock edge.
- OCIOSO:
  - esc_pc=0, mem_req=0.
  - If enable=1 at the edge: mem_addr<=pc_atual, mem_req<=1, wait counter<=0, go PEDE.
- PEDE:
  - mem_req held 1 and mem_addr held stable until mem_ack is sampled 1.
  - mem_ack=1: instr<=mem_rdata, instr_valid<=1, mem_req<=0, go ENTREGA.
  - mem_ack=0: counter increments.
  - Counter reaches MAX_WAIT with mem_ack=0: mem_req<=0, erro<=1, go OCIOSO.
  - mem_ack=1 on the same edge the counter would time out: ack wins, no error.
- ENTREGA:
  - instr and instr_valid held stable until instr_ready is sampled 1.
  - On accept: instr_valid<=0; entrada_pc<=alvo if desvio=1 on that edge, else (pc_atual+PC_INC) mod 2^ADDR_W; esc_pc<=1; go ATUALIZA.
- ATUALIZA:
  - esc_pc=1 for exactly this one cycle; the PC register loads entrada_pc at the end of it.
  - Next edge: esc_pc<=0, go OCIOSO.
- Next fetch address: the next fetch therefore samples the updated PC in OCIOSO.
- Latency: minimum 4 cycles per instruction (OCIOSO→PEDE→ENTREGA→ATUALIZA) with immediate ack and ready.
- Ignored inputs:
  - desvio/alvo are ignored except on the ENTREGA accept edge.
  - mem_ack is ignored outside PEDE.
  - instr_ready is ignored outside ENTREGA.
  - enable deasserting mid-fetch does not abort the fetch.
- Write-enable rules:
  - esc_pc is never asserted outside ATUALIZA.
  - entrada_pc holds its last value when esc_pc=0.
- erro: once set, cleared only by reset. Fetching continues normally after an error (re-enters PEDE on enable).
- Wrap-around: pc_atual=0xFF with PC_INC=1 gives entrada_pc=0x00.

Test Plan:
- Reset then basic fetch:
  - Stimulus: reset low 3 cycles, release; pc_atual=0x10, enable=1; mem_ack 1 cycle after req with mem_rdata=0xA5C3; instr_ready=1.
  - Required: mem_addr=0x10; instr=0xA5C3 with instr_valid for 1 cycle; entrada_pc=0x11; esc_pc high exactly 1 cycle; 4-cycle period.
- Memory wait states:
  - Stimulus: mem_ack delayed 5 cycles.
  - Required: mem_req and mem_addr stable for 6 cycles; erro stays 0.
- Timeout, and ack on the timeout edge:
  - Stimulus A: mem_ack never asserted.
  - Required A: mem_req drops after MAX_WAIT=15 cycles; erro=1 and sticky; esc_pc never pulses.
  - Stimulus B: repeat with mem_ack arriving on the timeout edge.
  - Required B: normal fetch, erro unchanged.
- Decoder back-pressure with branch:
  - Stimulus: instr_ready low 4 cycles, then high together with desvio=1, alvo=0x3C.
  - Required: instr held for 5 cycles; entrada_pc=0x3C; single esc_pc pulse.
- Wrap and mid-fetch reset:
  - Stimulus A: pc_atual=0xFF.
  - Required A: entrada_pc=0x00.
  - Stimulus B: assert reset while in PEDE, between clock edges.
  - Required B: mem_req falls before the next edge; all outputs 0; state OCIOSO.
